md_unit_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU.
- The controller raises md_start_E for MULT/MULTU/DIV/DIVU. The unit raises md_run_E while iterating so the controller can stall HI/LO readers.
- Generalises the fixed 32-bit mult/div to any even WIDTH, with a defined divide-by-zero result, abort-on-write and optional early termination.

---
 rtl/md_unit_iter.sv | 217 +++++++++++++++++++++
 tb/tb_md_unit_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_iter
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               Radix-2 shift-add multiply and restoring divide, one bit per
//               cycle, followed by a single sign-fix cycle. MTHI/MTLO writes
//               abort an operation in flight.
//               Optional macro MD_EARLY_TERM_EN: multiply stops iterating once
//               the remaining multiplier bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start_E,
  input  logic [1:0]       md_op_E,
  input  logic [WIDTH-1:0] src_a_E,
  input  logic [WIDTH-1:0] src_b_E,
  input  logic             hi_we_E,
  input  logic             lo_we_E,
  input  logic [WIDTH-1:0] hilo_wdata_E,
  output logic             md_run_E,
  output logic             md_done_E,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;        // bit1 divide, bit0 signed
  logic [WIDTH-1:0]   a_q, a_d;          // |multiplicand|, or raw dividend for the b=0 result
  logic [WIDTH-1:0]   b_q, b_d;          // |multiplier| (shifted right per step) or |divisor|
  logic               sa_q, sa_d;        // operand a was negative (signed ops only)
  logic               sb_q, sb_d;        // operand b was negative (signed ops only)
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, quotient/dividend}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               w_write;
  logic               w_abort;
  logic               w_run_last;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  assign w_write = hi_we_E | lo_we_E;
  assign w_abort = w_write && (state_q != S_IDLE);

  // Operand magnitudes at capture; negation of the most negative value yields
  // the correct unsigned magnitude.
  assign w_neg_a = md_op_E[0] & src_a_E[WIDTH-1];
  assign w_neg_b = md_op_E[0] & src_b_E[WIDTH-1];
  assign w_mag_a = w_neg_a ? -src_a_E : src_a_E;
  assign w_mag_b = w_neg_b ? -src_b_E : src_b_E;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right with carry.
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign w_mul_acc = b_q[0] ? {w_mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: the shifted partial remainder may need WIDTH+1 bits,
  // but after a successful subtract it always fits WIDTH bits again.
  assign w_div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
  assign w_div_diff = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
  assign w_div_acc  = {(w_div_ge ? w_div_diff : acc_q[2*WIDTH-2:WIDTH-1]),
                       acc_q[WIDTH-2:0], w_div_ge};

`ifdef MD_EARLY_TERM_EN
  // Early exit leaves the product scaled up by the skipped step count.
  assign w_run_last = (cnt_q == CNT_W'(1)) ||
                      (!op_q[1] && (b_q[WIDTH-1:1] == '0));
  assign w_prod_raw = acc_q >> cnt_q;
`else
  assign w_run_last = (cnt_q == CNT_W'(1));
  assign w_prod_raw = acc_q;
`endif

  assign w_prod = (sa_q ^ sb_q) ? -w_prod_raw : w_prod_raw;

  // Sign-corrected result presented to HI/LO during FIX.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_q == '0) begin
        w_res_hi = a_q;
        w_res_lo = '1;
      end else begin
        w_res_lo = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_res_hi = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; any HI/LO write while busy returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_start_E) state_d = S_RUN;
      S_RUN:   if (w_run_last) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_abort) state_d = S_IDLE;
  end

  // Output logic.
  always_comb begin
    md_run_E = (state_q != S_IDLE);
  end

  // Datapath next values: capture, iterate, fix-up, and MTHI/MTLO.
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start_E) begin
          op_d  = md_op_E;
          sa_d  = w_neg_a;
          sb_d  = w_neg_b;
          b_d   = w_mag_b;
          cnt_d = CNT_W'(WIDTH);
          if (md_op_E[1]) begin
            a_d   = src_a_E;
            acc_d = {{WIDTH{1'b0}}, w_mag_a};
          end else begin
            a_d   = w_mag_a;
            acc_d = '0;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q[1]) begin
          acc_d = w_div_acc;
        end else begin
          acc_d = w_mul_acc;
          b_d   = b_q >> 1;
        end
      end
      S_FIX: begin
        if (!w_write) begin
          hi_d   = w_res_hi;
          lo_d   = w_res_lo;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (hi_we_E) hi_d = hilo_wdata_E;
    if (lo_we_E) lo_d = hilo_wdata_E;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign md_done_E = done_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_iter
// Description : Directed bench for md_unit_iter (WIDTH=32) with a result
//               scoreboard and a small arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_iter;

  localparam int W = 32;
`ifdef MD_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         md_start_E;
  logic [1:0]   md_op_E;
  logic [W-1:0] src_a_E;
  logic [W-1:0] src_b_E;
  logic         hi_we_E;
  logic         lo_we_E;
  logic [W-1:0] hilo_wdata_E;
  logic         md_run_E;
  logic         md_done_E;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  md_unit_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .md_start_E   (md_start_E),
    .md_op_E      (md_op_E),
    .src_a_E      (src_a_E),
    .src_b_E      (src_b_E),
    .hi_we_E      (hi_we_E),
    .lo_we_E      (lo_we_E),
    .hilo_wdata_E (hilo_wdata_E),
    .md_run_E     (md_run_E),
    .md_done_E    (md_done_E),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference {HI,LO} for one operation.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, q, r;
    x = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
    y = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[1]) begin
      p = x * y;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Expected number of cycles md_run_E stays high.
  function automatic int run_len(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int k;
    m = (op[0] && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return (ET && !op[1]) ? k + 1 : W + 1;
  endfunction

  // Called one sample after the start edge; waits for md_done_E, checks
  // latency, busy time and the scoreboard result.
  task automatic wait_done(input string tag, input int exp_run, input int inject_at);
    int edges;
    int runs;
    logic [63:0] exp;
    edges = 1;
    runs  = 0;
    while (md_done_E !== 1'b1 && edges < 300) begin
      if (md_run_E === 1'b1) runs++;
      if (edges == inject_at) begin
        md_start_E = 1'b1;
        md_op_E    = 2'b10;
        src_a_E    = 32'd100;
        src_b_E    = 32'd7;
      end else begin
        md_start_E = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    md_start_E = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'(exp_run + 1));
    check({tag, "_runcycles"}, 64'(runs), 64'(exp_run));
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
    check({tag, "_hi"}, {32'b0, hi_out}, {32'b0, exp[63:32]});
    check({tag, "_lo"}, {32'b0, lo_out}, {32'b0, exp[31:0]});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {63'b0, md_done_E}, 64'd0);
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start_E = 1'b1;
    md_op_E    = op;
    src_a_E    = a;
    src_b_E    = b;
    @(posedge clk); #1;
    md_start_E = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int inject_at);
    sb.push_back(exp);
    drive_start(op, a, b);
    wait_done(tag, run_len(op, b), inject_at);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (md_done_E !== 1'b0) seen++;
    end
    check({tag, "_no_done"}, 64'(seen), 64'd0);
    check({tag, "_idle"}, {63'b0, md_run_E}, 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; md_start_E = 1'b0; md_op_E = 2'b00; src_a_E = '0; src_b_E = '0;
    hi_we_E = 1'b0; lo_we_E = 1'b0; hilo_wdata_E = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_run",  {63'b0, md_run_E},  64'd0);
    check("rst_done", {63'b0, md_done_E}, 64'd0);
    check("rst_hi",   {32'b0, hi_out},    64'd0);
    check("rst_lo",   {32'b0, lo_out},    64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    do_op("mult_neg",  2'b01, -32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    do_op("div_neg",   2'b11, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("divu",      2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    do_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    do_op("divu_zero", 2'b10, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 0);

    // MTLO at RUN cycle 5 aborts a DIVU; HI keeps 0x1234.
    drive_start(2'b10, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    lo_we_E = 1'b1; hilo_wdata_E = 32'hABCD;
    @(posedge clk); #1;
    lo_we_E = 1'b0;
    check("abort_run", {63'b0, md_run_E}, 64'd0);
    check("abort_lo",  {32'b0, lo_out},   64'h0000_ABCD);
    check("abort_hi",  {32'b0, hi_out},   64'h0000_1234);
    quiet("abort", W + 4);

    do_op("multu_5x3", 2'b00, 32'd5, 32'd3, 64'd15, 0);
    // A DIVU start pulsed while busy must be ignored.
    do_op("busy_start", 2'b00, 32'd2, 32'd3, 64'd6, 3);
    quiet("busy_start", 4);

    // MTHI and MTLO together.
    hi_we_E = 1'b1; lo_we_E = 1'b1; hilo_wdata_E = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    hi_we_E = 1'b0; lo_we_E = 1'b0;
    check("mthilo_hi", {32'b0, hi_out}, 64'h5A5A_0F0F);
    check("mthilo_lo", {32'b0, lo_out}, 64'h5A5A_0F0F);

    // MTHI in the start cycle: write lands and the start is still accepted.
    sb.push_back(64'd42);
    hi_we_E = 1'b1; hilo_wdata_E = 32'h77;
    md_start_E = 1'b1; md_op_E = 2'b00; src_a_E = 32'd6; src_b_E = 32'd7;
    @(posedge clk); #1;
    hi_we_E = 1'b0; md_start_E = 1'b0;
    check("wr_start_hi",  {32'b0, hi_out},   64'h77);
    check("wr_start_run", {63'b0, md_run_E}, 64'd1);
    wait_done("wr_start", run_len(2'b00, 32'd7), 0);

    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a  = $urandom;
      if (op[1]) begin
        b = $urandom_range(1, 5000);
        if (op[0] && $urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = (i < 4) ? $urandom : $urandom_range(0, 300);
      end
      do_op($sformatf("rand%0d", i), op, a, b, ref_md(op, a, b), 0);
    end

    // Reset during RUN of MULTU 7*9 discards it at once.
    drive_start(2'b00, 32'd7, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_run",  {63'b0, md_run_E},  64'd0);
    check("midrst_done", {63'b0, md_done_E}, 64'd0);
    check("midrst_hi",   {32'b0, hi_out},    64'd0);
    check("midrst_lo",   {32'b0, lo_out},    64'd0);
    quiet("midrst", W + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
